mem_sequencer: RTL

Byte-serial load/store sequencer between the CPU datapath and the 8-bit block RAM port. It replaces the fixed 1- and 4-byte load/store sequencing hard-wired into the CPU state machine with a single parametrised engine. The engine handles 1, 2, 4 or 8 byte accesses, sign/zero extension, a configurable memory read latency and pipelined byte reads. The CPU issues one request and waits for `done`; push/pop, load/store and long-immediate fetches all go through it.

---
 rtl/mem_sequencer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mem_sequencer.sv
// mem_sequencer: byte-serial load/store engine for an 8-bit RAM port.
// Big-endian 1/2/4/8 byte accesses with pipelined, latency-aware reads.
module mem_sequencer #(
  parameter int addr_width   = 9,
  parameter int data_width   = 32,
  parameter int read_latency = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_req,
  input  logic                  i_we,
  input  logic [1:0]            i_size,
  input  logic                  i_sign,
  input  logic [addr_width-1:0] i_addr,
  input  logic [data_width-1:0] i_wdata,
  output logic [data_width-1:0] o_rdata,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  output logic [addr_width-1:0] o_mem_raddr,
  input  logic [7:0]            i_mem_data_out,
  output logic [addr_width-1:0] o_mem_waddr,
  output logic [7:0]            o_mem_data_in,
  output logic                  o_mem_write
);

  localparam int DW = data_width;
  localparam int AW = addr_width;
  localparam int L  = read_latency;

  typedef enum logic [2:0] {
    IDLE, STORE, LOAD_ISSUE, LOAD_DRAIN, DONE
  } state_t;

  state_t r_state, w_state_n;

  logic [3:0]    r_cnt;
  logic [3:0]    r_cap;
  logic [1:0]    r_size;
  logic          r_sign;
  logic          r_err;
  logic [L-1:0]  r_vld;
  logic [DW-1:0] r_wshift;
  logic [DW-1:0] r_shift;
  logic [DW-1:0] r_rdata;
  logic [AW-1:0] r_mem_raddr;
  logic [AW-1:0] r_mem_waddr;
  logic [7:0]    r_mem_data_in;
  logic          r_mem_write;

  logic [7:0]    w_nbits;
  logic [7:0]    w_rnbits;
  logic          w_illegal;
  logic          w_accept;
  logic          w_issue;
  logic          w_capture;
  logic          w_last_cap;
  logic          w_msb;
  logic [DW-1:0] w_wjust;
  logic [DW-1:0] w_full;
  logic [DW-1:0] w_mask;
  logic [DW-1:0] w_ext;

  assign w_nbits    = 8'd8 << i_size;
  assign w_illegal  = w_nbits > 8'(DW);
  assign w_accept   = i_req & ~o_busy;
  assign w_issue    = r_state == LOAD_ISSUE;
  assign w_capture  = r_vld[L-1];
  assign w_last_cap = w_capture && (r_cap == 4'd1);

  // left-justify store data so byte i is always the top byte
  assign w_wjust  = i_wdata << (8'(DW) - w_nbits);
  assign w_rnbits = 8'd8 << r_size;
  assign w_full   = {r_shift[DW-9:0], i_mem_data_out};
  assign w_mask   = ~({DW{1'b1}} << w_rnbits);
  assign w_msb    = r_sign & |(w_full & (w_mask ^ (w_mask >> 1)));
  assign w_ext    = (w_full & w_mask) | ({DW{w_msb}} & ~w_mask);

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    unique case (r_state)
      IDLE, DONE: begin
        w_state_n = IDLE;
        if (i_req) begin
          if (w_illegal) w_state_n = DONE;
          else if (i_we) w_state_n = STORE;
          else           w_state_n = LOAD_ISSUE;
        end
      end
      STORE:
        if (r_cnt == 4'd0) w_state_n = DONE;
      LOAD_ISSUE:
        if (r_cnt == 4'd0) w_state_n = LOAD_DRAIN;
      LOAD_DRAIN:
        if (w_last_cap) w_state_n = DONE;
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt         <= '0;
      r_cap         <= '0;
      r_size        <= '0;
      r_sign        <= 1'b0;
      r_err         <= 1'b0;
      r_vld         <= '0;
      r_wshift      <= '0;
      r_shift       <= '0;
      r_rdata       <= '0;
      r_mem_raddr   <= '0;
      r_mem_waddr   <= '0;
      r_mem_data_in <= '0;
      r_mem_write   <= 1'b0;
    end else begin
      r_mem_write <= 1'b0;
      r_err       <= w_accept & w_illegal;
      r_vld       <= L'({r_vld, w_issue});
      if (w_capture) begin
        r_shift <= w_full;
        r_cap   <= r_cap - 4'd1;
      end
      if (w_last_cap) r_rdata <= w_ext;
      if (w_accept && !w_illegal) begin
        r_size  <= i_size;
        r_sign  <= i_sign;
        r_cnt   <= w_nbits[6:3] - 4'd1;
        r_cap   <= w_nbits[6:3];
        r_shift <= '0;
        if (i_we) begin
          r_mem_write   <= 1'b1;
          r_mem_waddr   <= i_addr;
          r_mem_data_in <= w_wjust[DW-1 -: 8];
          r_wshift      <= w_wjust << 8;
        end else begin
          r_mem_raddr <= i_addr;
        end
      end else if (r_state == STORE && r_cnt != 4'd0) begin
        r_mem_write   <= 1'b1;
        r_mem_waddr   <= r_mem_waddr + AW'(1);
        r_mem_data_in <= r_wshift[DW-1 -: 8];
        r_wshift      <= r_wshift << 8;
        r_cnt         <= r_cnt - 4'd1;
      end else if (w_issue && r_cnt != 4'd0) begin
        r_mem_raddr <= r_mem_raddr + AW'(1);
        r_cnt       <= r_cnt - 4'd1;
      end
    end
  end

  assign o_busy        = (r_state != IDLE) && (r_state != DONE);
  assign o_done        = r_state == DONE;
  assign o_err         = r_err;
  assign o_rdata       = r_rdata;
  assign o_mem_raddr   = r_mem_raddr;
  assign o_mem_waddr   = r_mem_waddr;
  assign o_mem_data_in = r_mem_data_in;
  assign o_mem_write   = r_mem_write;

endmodule
